h264_obuf: RTL
==============

# h264_obuf

Bitstream output buffer downstream of the H.264 packer stage. Accepts packed 32-bit bitstream words from the packer over a valid/ready handshake, stores up to DEPTH words, and exposes them to the host/DMA side through a random-access read port, a word count, and a clear strobe. It drives `h264_out`, `h264_buf_cnt`, and `h264_addr` consumption at the H264 top level, and back-pressures the packer when the buffer is held for readout.

## Interface

Parameters:
- `DEPTH`, 64: buffer depth in 32-bit words; power of two.
- `AW`, 6: address width, log2(DEPTH).

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  synchronous active-high reset.
- `wr_valid`  in  1  packer word valid.
- `wr_data`  in  32  packed bitstream word, MSB-first bit order.
- `wr_last`  in  1  qualifies `wr_data` as the final word of the frame.
- `wr_ready`  out  1  buffer can accept a word this cycle.
- `buf_clear`  in  1  host strobe: empty the buffer and release the hold.
- `rd_addr`  in  AW  host word read address.
- `rd_data`  out  32  registered read data.
- `buf_cnt`  out  AW+1  number of valid words, 0..DEPTH.
- `frame_done`  out  1  last word of the frame has been stored.
- `buf_irq`  out  1  one-cycle attention pulse (see Configuration).

## Operation

- Storage: DEPTH x 32 register array; write pointer `wp` is AW+1 bits wide; `buf_cnt` equals `wp`.
- FSM states:
  - ACCEPT: writes allowed.
  - HOLD: writes blocked until the host clears.
- ACCEPT -> HOLD when an accepted write makes `buf_cnt == DEPTH`, or when an accepted write has `wr_last=1`. Both can occur in the same cycle; the result is HOLD.
- HOLD -> ACCEPT on `buf_clear`.
- `buf_clear` in ACCEPT: `wp`=0 and the state stays ACCEPT.
- Write acceptance: `wr_ready = (state==ACCEPT) && !buf_clear`, combinational. A word is accepted when `wr_valid && wr_ready`. It is written to `mem[wp[AW-1:0]]` and `wp` increments by 1.
- `buf_clear` always wins over a same-cycle write. The write is not accepted and the packer must hold the word.
- `frame_done` is set when a word with `wr_last` is accepted and cleared by `buf_clear`.
- Read: `rd_data <= (rd_addr < buf_cnt) ? mem[rd_addr] : 32'h0`, evaluated against the pre-update `buf_cnt`. Reads are allowed in any state and have no side effects.
- Memory contents are not cleared by `buf_clear` or `rst`. Gating by `buf_cnt` makes stale data unreadable.

## Timing

- Reset values: `state`=ACCEPT, `wp`=0, `buf_cnt`=0, `wr_ready`=1 (when `buf_clear`=0), `rd_data`=0, `frame_done`=0, `buf_irq`=0.
- Write-to-count latency: `buf_cnt` reflects an accepted write on the next cycle.
- Write-to-read: a word accepted in cycle N is readable by `rd_addr` issued in cycle N+1. Data appears on `rd_data` in cycle N+2.
- Read latency: 1 cycle, address in cycle N, data in cycle N+1.
- Full transition: the write that makes the buffer full (word DEPTH) is accepted in cycle N. `wr_ready`=0 from cycle N+1.
- Clear: `buf_clear` in cycle N gives `buf_cnt`=0, `frame_done`=0, and state ACCEPT in cycle N+1. `wr_ready`=1 in N+1 if `buf_clear` is deasserted.
- Reset mid-frame: all state returns to reset values on the next edge. A partially filled frame is discarded.
- Throughput: one word per cycle in ACCEPT.

## Configuration

- `H264_OBUF_IRQ_EN`, defined:
  - `buf_irq` pulses high for exactly one cycle, the cycle after the ACCEPT -> HOLD transition.
  - Full and last in the same transition give a single pulse.
  - `buf_irq` is registered and is 0 in all other cycles.
- `H264_OBUF_IRQ_EN`, undefined:
  - `buf_irq` is tied to 0 and no IRQ logic is synthesized.
  - The host polls `buf_cnt`/`frame_done`.
  - All other behaviour is identical.

## Test plan

- Reset, then 3 writes (0xA0000001..0xA0000003), no `wr_last` -> `buf_cnt`=3, `frame_done`=0. Reading addr 1 returns 0xA0000002 one cycle later. Reading addr 5 returns 0x0.
- 64 back-to-back writes with `wr_valid` held high -> `wr_ready` drops the cycle after word 64, `buf_cnt`=64, and a 65th word is not accepted. With IRQ_EN, one `buf_irq` pulse.
- 10 writes, 10th with `wr_last` -> `frame_done`=1, `wr_ready`=0, `buf_cnt`=10. `buf_clear` -> next cycle `buf_cnt`=0, `frame_done`=0, `wr_ready`=1.
- `buf_clear` and `wr_valid` in the same cycle in ACCEPT with `buf_cnt`=5 -> the word is not accepted and `buf_cnt`=0. The same word retried next cycle gives `buf_cnt`=1 and mem[0]=that word.
- 64th word carrying `wr_last` -> single HOLD entry, `frame_done`=1, exactly one `buf_irq` pulse with IRQ_EN, and 0 without.
- `rst` asserted after 20 writes -> `buf_cnt`=0, `rd_data`=0, `frame_done`=0 next cycle. Reading addr 0 returns 0x0.

Source files
------------

// File: rtl/h264_obuf_if.sv
// Packer write handshake and host readout port of the H.264 bitstream output buffer.
interface h264_obuf_if #(
    parameter int unsigned AW = 6
);
    logic          wr_valid;
    logic [31:0]   wr_data;
    logic          wr_last;
    logic          wr_ready;
    logic          buf_clear;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic [AW:0]   buf_cnt;
    logic          frame_done;
    logic          buf_irq;

    modport master (
        output wr_valid, wr_data, wr_last, buf_clear, rd_addr,
        input  wr_ready, rd_data, buf_cnt, frame_done, buf_irq
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, buf_clear, rd_addr,
        output wr_ready, rd_data, buf_cnt, frame_done, buf_irq
    );
endinterface

// File: rtl/h264_obuf.sv
// H.264 bitstream output buffer: DEPTH x 32 store, random-access readout, hold until cleared.
// Define H264_OBUF_IRQ_EN to get a one-cycle buf_irq pulse on entering HOLD.
module h264_obuf #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input logic        clk,
    input logic        rst,
    h264_obuf_if.slave bus
);

    typedef enum logic {StAccept, StHold} state_e;

    state_e      state_q, state_d;
    logic [AW:0] wp_q, wp_d;
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_q;
    logic        frame_done_q;
    logic        wr_ready;
    logic        wr_en;
    logic        hold_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccept;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_entry = 1'b0;
        unique case (state_q)
            StAccept: begin
                // Full and last in the same write collapse into one HOLD entry.
                if (wr_en && (bus.wr_last || wp_q == (AW + 1)'(DEPTH - 1))) begin
                    state_d    = StHold;
                    hold_entry = 1'b1;
                end
            end
            StHold: begin
                if (bus.buf_clear) begin
                    state_d = StAccept;
                end
            end
            default: state_d = StAccept;
        endcase
    end

    always_comb begin
        wr_ready = (state_q == StAccept) && !bus.buf_clear;
        wr_en    = bus.wr_valid && wr_ready;
    end

    always_comb begin
        wp_d = wp_q;
        if (bus.buf_clear) begin
            wp_d = '0;
        end else if (wr_en) begin
            wp_d = wp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q         <= '0;
            frame_done_q <= 1'b0;
            rd_data_q    <= 32'h0;
        end else begin
            wp_q <= wp_d;
            if (bus.buf_clear) begin
                frame_done_q <= 1'b0;
            end else if (wr_en && bus.wr_last) begin
                frame_done_q <= 1'b1;
            end
            // Gating by the pre-update count hides stale words left in the array.
            rd_data_q <= ({1'b0, bus.rd_addr} < wp_q) ? mem[bus.rd_addr] : 32'h0;
        end
    end

    // Array is intentionally not reset or cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp_q[AW-1:0]] <= bus.wr_data;
        end
    end

`ifdef H264_OBUF_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= hold_entry;
        end
    end

    assign bus.buf_irq = irq_q;
`else
    logic unused_hold_entry;
    assign unused_hold_entry = hold_entry;
    assign bus.buf_irq       = 1'b0;
`endif

    assign bus.wr_ready   = wr_ready;
    assign bus.rd_data    = rd_data_q;
    assign bus.buf_cnt    = wp_q;
    assign bus.frame_done = frame_done_q;

endmodule
